// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - 256-bit cache line to 4-beat 64-bit memory burst adaptor
module cacheline_burst_adaptor #(
  parameter int s_line    = 256,
  parameter int s_burst   = 64,
  parameter int s_offset  = 5,
  parameter int num_beats = s_line / s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int cnt_w = $clog2(num_beats);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t             state, state_nxt;
  logic [cnt_w-1:0]   count, count_nxt;
  logic [s_line-1:0]  buffer, buffer_nxt;
  logic [s_line-1:0]  line_nxt;
  logic [s_burst-1:0] burst_nxt;
  logic [31:0]        address_nxt;
  logic               read_nxt, write_nxt, resp_nxt;
  logic               last_beat;

  // Offset bits never reach memory; the line address is always aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[s_offset-1:0];

  assign last_beat = (count == cnt_w'(num_beats - 1));

  // State register; reset mid-burst abandons the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: read wins over write, beat 3 handshake ends a burst.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (read_i)       state_nxt = RD;
        else if (write_i) state_nxt = WR;
      end
      RD:      if (resp_i && last_beat) state_nxt = DONE;
      WR:      if (resp_i && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered datapath and outputs.
  always_comb begin
    count_nxt   = count;
    buffer_nxt  = buffer;
    line_nxt    = line_o;
    burst_nxt   = burst_o;
    address_nxt = address_o;
    read_nxt    = read_o;
    write_nxt   = write_o;
    resp_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (read_i) begin
          address_nxt = {address_i[31:s_offset], {s_offset{1'b0}}};
          read_nxt    = 1'b1;
          count_nxt   = '0;
        end else if (write_i) begin
          address_nxt = {address_i[31:s_offset], {s_offset{1'b0}}};
          buffer_nxt  = line_i;
          burst_nxt   = line_i[s_burst-1:0];
          write_nxt   = 1'b1;
          count_nxt   = '0;
        end
      end
      RD: begin
        if (resp_i) begin
          buffer_nxt[count*s_burst +: s_burst] = burst_i;
          count_nxt = count + 1'b1;
          if (last_beat) begin
            read_nxt = 1'b0;
            line_nxt = buffer_nxt;
            resp_nxt = 1'b1;
          end
        end
      end
      WR: begin
        if (resp_i) begin
          count_nxt = count + 1'b1;
          if (last_beat) begin
            write_nxt = 1'b0;
            resp_nxt  = 1'b1;
          end else begin
            burst_nxt = buffer[count_nxt*s_burst +: s_burst];
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      buffer    <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      count     <= count_nxt;
      buffer    <= buffer_nxt;
      line_o    <= line_nxt;
      burst_o   <= burst_nxt;
      address_o <= address_nxt;
      read_o    <= read_nxt;
      write_o   <= write_nxt;
      resp_o    <= resp_nxt;
    end
  end

endmodule
